// File: rtl/reorder_buffer_multi.sv
// Purpose : in-order-retire reorder buffer; multi-lane allocate, multi-port writeback, multi-slot retire.
// Latency : writeback at edge N -> retire-eligible at edge N+1 -> retire outputs valid after edge N+1.
// Backpress: issueReady drops when fewer than ISSUE_WIDTH entries are free; issue is then ignored whole.
//
// Ports:
//   clock, reset (sync, active-high), flush (sync clear of all entries)
//   issueValid/ProgramCounter/DestinationRegister/IsStore -> issueReady, allocTag, freeCount
//   wbValid/wbTag/wbResult   : result capture per writeback port
//   retireValid/ProgramCounter/DestinationRegister/Result/IsStore : registered retire slots
//   empty, full              : occupancy flags from registered count
module reorder_buffer_multi #(
    parameter int DEPTH        = 16,
    parameter int TAG_WIDTH    = $clog2(DEPTH),
    parameter int ISSUE_WIDTH  = 2,
    parameter int WB_PORTS     = 3,
    parameter int RETIRE_WIDTH = 2
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              flush,
    input  logic [ISSUE_WIDTH-1:0]            issueValid,
    input  logic [ISSUE_WIDTH*32-1:0]         issueProgramCounter,
    input  logic [ISSUE_WIDTH*5-1:0]          issueDestinationRegister,
    input  logic [ISSUE_WIDTH-1:0]            issueIsStore,
    output logic                              issueReady,
    output logic [ISSUE_WIDTH*TAG_WIDTH-1:0]  allocTag,
    output logic [TAG_WIDTH:0]                freeCount,
    input  logic [WB_PORTS-1:0]               wbValid,
    input  logic [WB_PORTS*TAG_WIDTH-1:0]     wbTag,
    input  logic [WB_PORTS*32-1:0]            wbResult,
    output logic [RETIRE_WIDTH-1:0]           retireValid,
    output logic [RETIRE_WIDTH*32-1:0]        retireProgramCounter,
    output logic [RETIRE_WIDTH*5-1:0]         retireDestinationRegister,
    output logic [RETIRE_WIDTH*32-1:0]        retireResult,
    output logic [RETIRE_WIDTH-1:0]           retireIsStore,
    output logic                              empty,
    output logic                              full
);

    localparam logic [TAG_WIDTH:0] DEPTH_CNT = (TAG_WIDTH+1)'(DEPTH);
    localparam logic [TAG_WIDTH:0] ISSUE_CNT = (TAG_WIDTH+1)'(ISSUE_WIDTH);

    typedef struct packed {
        logic [31:0] programCounter;
        logic [4:0]  destinationRegister;
        logic        isStore;
        logic [31:0] result;
    } entry_t;

    entry_t                 entries      [DEPTH];
    logic [DEPTH-1:0]       occupied;
    logic [DEPTH-1:0]       resultsReady;
    logic [TAG_WIDTH-1:0]   head;
    logic [TAG_WIDTH-1:0]   tail;
    logic [TAG_WIDTH:0]     count;

    logic [TAG_WIDTH:0]     allocCount;
    logic [TAG_WIDTH:0]     retireCount;
    logic [RETIRE_WIDTH-1:0] retOk;
    logic [TAG_WIDTH-1:0]   retIdx       [RETIRE_WIDTH];

    always_comb begin
        freeCount  = DEPTH_CNT - count;
        issueReady = (freeCount >= ISSUE_CNT);
        empty      = (count == '0);
        full       = (count == DEPTH_CNT);
        allocTag   = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            allocTag[i*TAG_WIDTH +: TAG_WIDTH] = tail + TAG_WIDTH'(i);
        end
    end

    // Lanes are compacted, so the popcount also tells how far tail moves.
    always_comb begin
        allocCount = '0;
        if (issueReady) begin
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                allocCount = allocCount + (TAG_WIDTH+1)'(issueValid[i]);
            end
        end
    end

    // Retire chain: slot j goes only if every older slot also goes.
    always_comb begin
        logic                 chainOk;
        logic [TAG_WIDTH-1:0] idx;
        chainOk     = 1'b1;
        idx         = '0;
        retOk       = '0;
        retireCount = '0;
        for (int j = 0; j < RETIRE_WIDTH; j++) begin
            idx       = head + TAG_WIDTH'(j);
            retIdx[j] = idx;
            chainOk   = chainOk && occupied[idx] && resultsReady[idx];
            retOk[j]  = chainOk;
            if (chainOk) begin
                retireCount = retireCount + (TAG_WIDTH+1)'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head                      <= '0;
            tail                      <= '0;
            count                     <= '0;
            occupied                  <= '0;
            resultsReady              <= '0;
            retireValid               <= '0;
            retireProgramCounter      <= '0;
            retireDestinationRegister <= '0;
            retireResult              <= '0;
            retireIsStore             <= '0;
        end else begin
            // Highest port first so the lowest-indexed port's write lands last.
            for (int p = WB_PORTS-1; p >= 0; p--) begin
                if (wbValid[p] && occupied[wbTag[p*TAG_WIDTH +: TAG_WIDTH]]) begin
                    entries[wbTag[p*TAG_WIDTH +: TAG_WIDTH]].result <= wbResult[p*32 +: 32];
                    resultsReady[wbTag[p*TAG_WIDTH +: TAG_WIDTH]]   <= 1'b1;
                end
            end

            // Placed after writeback so a retiring entry always ends up cleared.
            for (int j = 0; j < RETIRE_WIDTH; j++) begin
                if (retOk[j]) begin
                    occupied[retIdx[j]]     <= 1'b0;
                    resultsReady[retIdx[j]] <= 1'b0;
                end
                retireProgramCounter[j*32 +: 32]    <= retOk[j] ? entries[retIdx[j]].programCounter : 32'h0;
                retireDestinationRegister[j*5 +: 5] <= retOk[j] ? entries[retIdx[j]].destinationRegister : 5'h0;
                retireResult[j*32 +: 32]            <= retOk[j] ? entries[retIdx[j]].result : 32'h0;
                retireIsStore[j]                    <= retOk[j] && entries[retIdx[j]].isStore;
            end
            retireValid <= retOk;

            // Allocated slots are free in registered state, so they never collide with retiring ones.
            if (issueReady) begin
                for (int i = 0; i < ISSUE_WIDTH; i++) begin
                    if (issueValid[i]) begin
                        occupied[allocTag[i*TAG_WIDTH +: TAG_WIDTH]]     <= 1'b1;
                        resultsReady[allocTag[i*TAG_WIDTH +: TAG_WIDTH]] <= 1'b0;
                        entries[allocTag[i*TAG_WIDTH +: TAG_WIDTH]].programCounter      <= issueProgramCounter[i*32 +: 32];
                        entries[allocTag[i*TAG_WIDTH +: TAG_WIDTH]].destinationRegister <= issueDestinationRegister[i*5 +: 5];
                        entries[allocTag[i*TAG_WIDTH +: TAG_WIDTH]].isStore             <= issueIsStore[i];
                    end
                end
            end

            head  <= head + retireCount[TAG_WIDTH-1:0];
            tail  <= tail + allocCount[TAG_WIDTH-1:0];
            count <= count + allocCount - retireCount;
        end
    end

    // Valid lanes must form a contiguous run starting at lane 0 (mask of form 0..01..1).
    issueCompacted: assert property (@(posedge clock) disable iff (reset)
        ((issueValid & (issueValid + ISSUE_WIDTH'(1))) == '0));

endmodule

// File: doc/reorder_buffer_multi.md
Name: reorder_buffer_multi

Overview:
- Parametrised in-order-retire reorder buffer (ROB) for the dual-issue core.
- Generalises the fixed 4-bit-tag, single-retire queue to configurable depth, issue width, writeback port count and retire width.
- Sits between the issuer (allocation), the upper/lower execute and memory writeback paths (result capture) and the register file and store commit path (retirement).
- Adds a pipeline flush that the previous queue did not have.

Parameters:
DEPTH, 16, entry count; power of two, >= 4.
TAG_WIDTH, $clog2(DEPTH), age-tag width; equals the entry index.
ISSUE_WIDTH, 2, allocation lanes per cycle.
WB_PORTS, 3, writeback ports (upper ALU, lower ALU, memory).
RETIRE_WIDTH, 2, maximum retirements per cycle.

Ports:
clock  in  1  system clock; all state on the rising edge.
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous clear of all entries (mispredict/exception).
issueValid  in  ISSUE_WIDTH  per-lane allocate request; lanes must be compacted from lane 0 upward.
issueProgramCounter  in  ISSUE_WIDTH*32  PC per lane.
issueDestinationRegister  in  ISSUE_WIDTH*5  rd per lane.
issueIsStore  in  ISSUE_WIDTH  lane carries a store.
issueReady  out  1  high when DEPTH-count >= ISSUE_WIDTH.
allocTag  out  ISSUE_WIDTH*TAG_WIDTH  combinational; lane i tag = (tail+i) mod DEPTH.
freeCount  out  TAG_WIDTH+1  DEPTH-count, registered state.
wbValid  in  WB_PORTS  result valid per port.
wbTag  in  WB_PORTS*TAG_WIDTH  target entry per port.
wbResult  in  WB_PORTS*32  result per port.
retireValid  out  RETIRE_WIDTH  registered; slot j retired this cycle.
retireProgramCounter  out  RETIRE_WIDTH*32  registered.
retireDestinationRegister  out  RETIRE_WIDTH*5  registered.
retireResult  out  RETIRE_WIDTH*32  registered.
retireIsStore  out  RETIRE_WIDTH  registered; store-commit qualifier.
empty  out  1  count==0.
full  out  1  count==DEPTH.

Behaviour:
- State:
  - Per entry: occupied, resultsReady, programCounter, destinationRegister, isStore, result.
  - Pointers: head and tail (TAG_WIDTH bits, wrap mod DEPTH).
  - count (TAG_WIDTH+1 bits).
- Reset and flush (identical effect): head=tail=count=0; all occupied/resultsReady=0; retireValid=0; retire data outputs=0; issueReady=1; empty=1; full=0. Flush overrides same-cycle issue, writeback and retire.
- Allocation:
  - When issueReady=1, each valid lane i writes entry tail+i with occupied=1, resultsReady=0.
  - tail advances by popcount(issueValid).
  - When issueReady=0, all lanes are ignored; no partial allocation.
  - A non-compacted issueValid (e.g. 2'b10) is a protocol error; the RTL asserts on it in simulation.
- Writeback:
  - Each port with wbValid sets result and resultsReady=1 on entry wbTag at the edge.
  - A writeback to an unoccupied entry is ignored.
  - Two ports targeting the same tag in one cycle is a protocol error; the lowest-indexed port wins.
- Retire:
  - At each edge, slot j (j=0..RETIRE_WIDTH-1) retires entry head+j iff that entry and all lower slots are occupied and resultsReady in registered state. Retirement stops at the first not-ready entry.
  - Retired entries are cleared; head advances by the retire count; retire outputs are registered at that same edge.
  - Latency: a writeback at edge N makes the entry retire-eligible at edge N+1, so retireValid is high in the cycle after edge N+1. No same-edge writeback-to-retire bypass.
  - Non-retiring slots drive retireValid=0; their data fields are don't-care.
  - Stores retire like any other entry, with retireIsStore=1. rd=0 entries retire normally; the register file ignores x0.
- Count:
  - count_next = count + allocated - retired.
  - Simultaneous allocate and retire is legal.
  - issueReady uses registered count only, with no credit for same-cycle retirement.
- Wrap-around: pointer arithmetic wraps mod DEPTH. Slot j reading index head+j wraps correctly across the DEPTH-1 to 0 boundary.

Test Plan:
- Reset, then issue 2 lanes (PC 0x100, 0x104; rd 5, 6) -> allocTag 0,1; freeCount 14. Writeback both -> next cycle retireValid=2'b11 with rd 5, 6 and correct results; empty=1.
- Out-of-order writeback: allocate tags 0,1,2; write back tag 2, then tag 1, then tag 0 -> no retire until tag 0 completes. Then tags 0,1 retire in one cycle and tag 2 the next cycle.
- Fill to 16 entries -> full=1, issueReady=0, and an issue attempt is ignored (tail unchanged). Retire 2 -> issueReady=1.
- Wrap: cycle 40 allocations through DEPTH=16 with immediate writebacks -> tags wrap 15 to 0; retire order matches issue PC order with no loss.
- Flush with 7 entries pending plus same-cycle issue and writeback -> next cycle count=0, empty=1, retireValid=0; the following allocation gets tag 0.
- Store entry with rd=0 written back -> retireIsStore=1, retireDestinationRegister=0, retireValid=1.
